// File: rtl/spi_slave_receiver.sv
// SPI mode-3 (CPOL=1, CPHA=1) slave receiver.
// SCLK/CS/MOSI/DC are synchronised into sys_clk, SCLK rises shift MOSI in MSB
// first, and each completed byte is queued with its DC tag in a FWFT FIFO.
module spi_slave_receiver #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic                             spi_sclk,
  input  logic                             spi_cs,
  input  logic                             spi_mosi,
  input  logic                             lcd_dc,
  output logic [7:0]                       rx_data_o,
  output logic                             rx_dc_o,
  output logic                             rx_valid_o,
  input  logic                             rx_ready_i,
  output logic                             frame_start_o,
  output logic                             frame_end_o,
  output logic                             frame_partial_o,
  output logic                             rx_overflow_o,
  input  logic                             ovf_clr_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SET_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } state_t;

  // Synchroniser chains
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] dc_sync_q;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   dc_s;

  // Edge detection stage
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic                   sclk_rise_q;
  logic                   cs_fall_q;
  logic                   cs_rise_q;
  logic                   mosi_e_q;
  logic                   dc_e_q;

  // Post-reset CS qualification
  logic [SET_W-1:0]       settle_q;
  logic                   cs_armed_q;

  // Receive FSM
  state_t                 state_q;
  logic [6:0]             shift_q;
  logic [2:0]             bit_cnt_q;
  logic                   frame_start_q;
  logic                   frame_end_q;
  logic                   frame_partial_q;
  logic                   push_q;
  logic [8:0]             push_data_q;

  // FIFO
  logic [8:0]             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [LVL_W-1:0]       count_q;
  logic [LVL_W-1:0]       count_d;
  logic                   ovf_q;
  logic                   not_empty;
  logic                   full;
  logic                   pop;
  logic                   wr_en;
  logic                   drop;
  logic [8:0]             head;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];

  // Bring the SPI pins into the sys_clk domain; CS/SCLK idle high
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], lcd_dc};
    end
  end

  // Detect edges against the previous synced value; data/DC are delayed
  // alongside so the FSM sees the MOSI/DC belonging to the SCLK rise
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_rise_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      mosi_e_q    <= 1'b0;
      dc_e_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      sclk_rise_q <= sclk_s & ~sclk_prev_q;
      cs_fall_q   <= ~cs_s & cs_prev_q;
      cs_rise_q   <= cs_s & ~cs_prev_q;
      mosi_e_q    <= mosi_s;
      dc_e_q      <= dc_s;
    end
  end

  // Accept a CS fall only after CS has been seen high once the synchronisers
  // hold real pin values: the reset value of 1 would otherwise fake a fall
  // when a frame is already in progress as reset is released.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      settle_q   <= '0;
      cs_armed_q <= 1'b0;
    end else if (settle_q != SET_W'(SYNC_STAGES)) begin
      settle_q <= settle_q + SET_W'(1);
    end else if (cs_s) begin
      cs_armed_q <= 1'b1;
    end
  end

  // Frame/byte FSM with registered pulse outputs and byte push strobe
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q         <= ST_IDLE;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      frame_partial_q <= 1'b0;
      push_q          <= 1'b0;
      push_data_q     <= '0;
    end else begin
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      frame_partial_q <= 1'b0;
      push_q          <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_q && cs_armed_q) begin
            state_q       <= ST_RECV;
            bit_cnt_q     <= '0;
            frame_start_q <= 1'b1;
          end
        end
        ST_RECV: begin
          if (cs_rise_q) begin
            state_q         <= ST_IDLE;
            frame_end_q     <= 1'b1;
            frame_partial_q <= (bit_cnt_q != 3'd0);
            bit_cnt_q       <= '0;
          end else if (sclk_rise_q) begin
            shift_q   <= {shift_q[5:0], mosi_e_q};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              push_q      <= 1'b1;
              push_data_q <= {dc_e_q, shift_q, mosi_e_q};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs
  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == LVL_W'(FIFO_DEPTH));
    pop       = not_empty & rx_ready_i;
    wr_en     = push_q & (~full | pop);
    drop      = push_q & full & ~pop;
    count_d   = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + LVL_W'(1);
    end else if (pop && !wr_en) begin
      count_d = count_q - LVL_W'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  // FIFO pointers, level and sticky overflow (clear has priority)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end else if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Output head of FIFO, forced to zero while empty
  always_comb begin
    head            = mem_q[rd_ptr_q];
    rx_data_o       = '0;
    rx_dc_o         = 1'b0;
    if (not_empty) begin
      rx_data_o = head[7:0];
      rx_dc_o   = head[8];
    end
    rx_valid_o      = not_empty;
    fifo_level_o    = count_q;
    rx_overflow_o   = ovf_q;
    frame_start_o   = frame_start_q;
    frame_end_o     = frame_end_q;
    frame_partial_o = frame_partial_q;
  end

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Self-checking bench for spi_slave_receiver: drives mode-3 SPI frames and
// compares received bytes against an in-bench list of fully clocked bytes.
module tb_spi_slave_receiver;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             spi_sclk, spi_cs, spi_mosi, lcd_dc;
  logic [7:0]       rx_data_o;
  logic             rx_dc_o, rx_valid_o, rx_ready_i;
  logic             frame_start_o, frame_end_o, frame_partial_o;
  logic             rx_overflow_o, ovf_clr_i;
  logic [LVL_W-1:0] fifo_level_o;

  int errors = 0;
  int checks = 0;
  int n_start, n_end, n_part, n_part_alone, lvl_max;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];

  spi_slave_receiver #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .spi_sclk(spi_sclk), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .lcd_dc(lcd_dc), .rx_data_o(rx_data_o), .rx_dc_o(rx_dc_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .frame_start_o(frame_start_o),
    .frame_end_o(frame_end_o), .frame_partial_o(frame_partial_o),
    .rx_overflow_o(rx_overflow_o), .ovf_clr_i(ovf_clr_i), .fifo_level_o(fifo_level_o)
  );

  always #5 sys_clk = ~sys_clk;

  // One sys_clk cycle: log a pop that the coming edge performs, then observe pulses.
  task automatic tick();
    if (rx_valid_o && rx_ready_i) rx_q.push_back({rx_dc_o, rx_data_o});
    @(posedge sys_clk);
    #1;
    if (frame_start_o) n_start++;
    if (frame_end_o) n_end++;
    if (frame_partial_o) n_part++;
    if (frame_partial_o && !frame_end_o) n_part_alone++;
    if (int'(fifo_level_o) > lvl_max) lvl_max = int'(fifo_level_o);
  endtask

  task automatic clear_stats();
    n_start = 0; n_end = 0; n_part = 0; n_part_alone = 0; lvl_max = 0;
    rx_q.delete();
    exp_q.delete();
  endtask

  // mode 0: plain; 1: check rx_valid latency on 8th rise; 2: pop in the push cycle
  task automatic send_byte(input logic [7:0] b, input logic dc, input int nbits, input int mode);
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b0;
      spi_mosi = b[7-i];
      lcd_dc   = dc;
      repeat (4) tick();
      spi_sclk = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (i == 7 && k == 3 && mode == 1) begin
          checks++;
          if (rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: rx_valid_o=%0b expected 0 at cycle %0d", rx_valid_o, SYNC + 1);
          end
        end
        if (i == 7 && k == 3 && mode == 2) rx_ready_i = 1'b1;
      end
      if (i == 7 && mode == 1) begin
        tick();
        checks++;
        if (rx_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL latency_rise: rx_valid_o=%0b expected 1 at cycle %0d", rx_valid_o, SYNC + 2);
        end
      end
      if (i == 7 && mode == 2) begin
        tick();
        rx_ready_i = 1'b0;
      end
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic cs_high();
    repeat (4) tick();
    spi_cs = 1'b1;
    repeat (8) tick();
  endtask

  task automatic drain();
    rx_ready_i = 1'b1;
    repeat (DEPTH + 4) tick();
    rx_ready_i = 1'b0;
  endtask

  // Received stream must equal the expected stream exactly
  task automatic compare_stream(input string name);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes expected %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got dc=%0b data=%02h expected dc=%0b data=%02h",
                 name, i, rx_q[i][8], rx_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic test_reset();
    clear_stats();
    checks++;
    if ({rx_valid_o, rx_dc_o, rx_data_o, rx_overflow_o, frame_start_o, frame_end_o,
         frame_partial_o, fifo_level_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b data=%02h level=%0d ovf=%0b expected all 0",
               rx_valid_o, rx_data_o, fifo_level_o, rx_overflow_o);
    end
    sys_rst_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (rx_valid_o !== 1'b0 || fifo_level_o !== '0 || n_start != 0) begin
      errors++;
      $display("FAIL reset_idle: valid=%0b level=%0d starts=%0d expected 0/0/0",
               rx_valid_o, fifo_level_o, n_start);
    end
  endtask

  task automatic test_single();
    clear_stats();
    cs_low();
    send_byte(8'hA5, 1'b1, 8, 1);
    exp_q.push_back({1'b1, 8'hA5});
    cs_high();
    checks++;
    if (fifo_level_o !== LVL_W'(1)) begin
      errors++; $display("FAIL single_level: got %0d expected 1", fifo_level_o);
    end
    checks++;
    if ({rx_dc_o, rx_data_o} !== 9'h1A5) begin
      errors++; $display("FAIL single_head: got dc=%0b data=%02h expected dc=1 data=a5", rx_dc_o, rx_data_o);
    end
    checks++;
    if (n_start != 1 || n_end != 1 || n_part != 0) begin
      errors++;
      $display("FAIL single_pulses: start=%0d end=%0d partial=%0d expected 1/1/0", n_start, n_end, n_part);
    end
    drain();
    compare_stream("single");
  endtask

  task automatic test_stream();
    logic [7:0] b;
    logic       d;
    clear_stats();
    rx_ready_i = 1'b1;
    cs_low();
    send_byte(8'h2A, 1'b0, 8, 0); exp_q.push_back({1'b0, 8'h2A});
    send_byte(8'h00, 1'b1, 8, 0); exp_q.push_back({1'b1, 8'h00});
    send_byte(8'hFF, 1'b1, 8, 0); exp_q.push_back({1'b1, 8'hFF});
    send_byte(8'h81, 1'b1, 8, 0); exp_q.push_back({1'b1, 8'h81});
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      d = 1'($urandom);
      send_byte(b, d, 8, 0);
      exp_q.push_back({d, b});
    end
    cs_high();
    rx_ready_i = 1'b0;
    compare_stream("stream");
    checks++;
    if (lvl_max != 1) begin
      errors++; $display("FAIL stream_level_max: got %0d expected 1", lvl_max);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    logic       d;
    int         sent;
    clear_stats();
    sent = DEPTH + 1;
    cs_low();
    for (int n = 0; n < sent; n++) begin
      b = 8'($urandom);
      d = 1'($urandom);
      send_byte(b, d, 8, 0);
      if (n < DEPTH) exp_q.push_back({d, b});
    end
    repeat (4) tick();
    checks++;
    if (fifo_level_o !== LVL_W'(DEPTH)) begin
      errors++; $display("FAIL ovf_level: got %0d expected %0d", fifo_level_o, DEPTH);
    end
    checks++;
    if (rx_overflow_o !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %0b expected 1", rx_overflow_o);
    end
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    tick();
    checks++;
    if (rx_overflow_o !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %0b expected 0", rx_overflow_o);
    end
    // Clear held across a dropped byte: clear must beat the set
    ovf_clr_i = 1'b1;
    send_byte(8'($urandom), 1'b0, 8, 0);
    repeat (2) tick();
    ovf_clr_i = 1'b0;
    tick();
    checks++;
    if (rx_overflow_o !== 1'b0 || fifo_level_o !== LVL_W'(DEPTH)) begin
      errors++;
      $display("FAIL ovf_clear_wins: ovf=%0b level=%0d expected 0/%0d", rx_overflow_o, fifo_level_o, DEPTH);
    end
    cs_high();
    drain();
    compare_stream("ovf");
  endtask

  task automatic test_partial();
    clear_stats();
    rx_ready_i = 1'b1;
    cs_low();
    send_byte(8'($urandom), 1'b1, 5, 0);
    cs_high();
    checks++;
    if (n_part != 1 || n_end != 1 || n_part_alone != 0) begin
      errors++;
      $display("FAIL partial_pulse: partial=%0d end=%0d lone=%0d expected 1/1/0", n_part, n_end, n_part_alone);
    end
    checks++;
    if (rx_q.size() != 0) begin
      errors++; $display("FAIL partial_nopush: got %0d bytes expected 0", rx_q.size());
    end
    cs_low();
    send_byte(8'h3C, 1'b0, 8, 0);
    exp_q.push_back({1'b0, 8'h3C});
    cs_high();
    rx_ready_i = 1'b0;
    compare_stream("after_partial");
    checks++;
    if (n_part != 1) begin
      errors++; $display("FAIL partial_full_frame: partial=%0d expected 1", n_part);
    end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] b;
    logic       d;
    clear_stats();
    cs_low();
    for (int n = 0; n <= DEPTH; n++) begin
      b = 8'($urandom);
      d = 1'($urandom);
      send_byte(b, d, 8, (n == DEPTH) ? 2 : 0);
      exp_q.push_back({d, b});
    end
    checks++;
    if (fifo_level_o !== LVL_W'(DEPTH) || rx_overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_push: level=%0d ovf=%0b expected %0d/0", fifo_level_o, rx_overflow_o, DEPTH);
    end
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL full_pop_count: got %0d pops expected 1", rx_q.size());
    end
    cs_high();
    drain();
    compare_stream("full_pop_push");
  endtask

  task automatic test_reset_midframe();
    clear_stats();
    cs_low();
    send_byte(8'h11, 1'b1, 8, 0);
    send_byte(8'h22, 1'b1, 8, 0);
    send_byte(8'h33, 1'b1, 3, 0);
    repeat (4) tick();
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_valid_o, rx_data_o, rx_overflow_o, fifo_level_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%0b data=%02h level=%0d expected 0", rx_valid_o, rx_data_o, fifo_level_o);
    end
    repeat (2) tick();
    sys_rst_n = 1'b1;
    clear_stats();
    // Rest of the interrupted frame, CS still low: must be ignored
    send_byte(8'h33, 1'b1, 5, 0);
    send_byte(8'h99, 1'b1, 8, 0);
    cs_high();
    checks++;
    if (n_start != 0 || n_end != 0 || fifo_level_o !== '0) begin
      errors++;
      $display("FAIL midreset_ghost: start=%0d end=%0d level=%0d expected 0/0/0", n_start, n_end, fifo_level_o);
    end
    cs_low();
    send_byte(8'h55, 1'b0, 8, 0);
    exp_q.push_back({1'b0, 8'h55});
    cs_high();
    checks++;
    if (n_start != 1 || n_end != 1) begin
      errors++; $display("FAIL midreset_frame: start=%0d end=%0d expected 1/1", n_start, n_end);
    end
    drain();
    compare_stream("midreset");
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    spi_sclk   = 1'b1;
    spi_cs     = 1'b1;
    spi_mosi   = 1'b0;
    lcd_dc     = 1'b0;
    rx_ready_i = 1'b0;
    ovf_clr_i  = 1'b0;
    clear_stats();
    repeat (3) tick();
    test_reset();
    test_single();
    test_stream();
    test_overflow();
    test_partial();
    test_full_pop_push();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
